// File: rtl/cnt_down_timer.sv
// Loadable BCD MM:SS countdown timer, one decrement per ce pulse while running.
// Control FSM IDLE/RUN/PAUSE/EXPIRED; done pulses for one clock on reaching 00:00.
module cnt_down_timer #(
    parameter int MIN_T_MAX = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       load,
    input  logic [3:0] ld_min_t,
    input  logic [3:0] ld_min_u,
    input  logic [3:0] ld_sec_t,
    input  logic [3:0] ld_sec_u,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       expired,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam logic [3:0] MT_MAX = 4'(MIN_T_MAX);

    state_t     state, state_nx;
    logic [3:0] min_t_nx, min_u_nx, sec_t_nx, sec_u_nx;
    logic       done_nx;
    logic       is_zero, is_one;

    assign is_zero = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 4'd0) && (sec_u == 4'd0);
    assign is_one  = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 4'd0) && (sec_u == 4'd1);

    always_comb begin
        state_nx = state;
        min_t_nx = min_t;
        min_u_nx = min_u;
        sec_t_nx = sec_t;
        sec_u_nx = sec_u;
        done_nx  = 1'b0;
        if (load) begin
            state_nx = IDLE;
            min_t_nx = (ld_min_t > MT_MAX) ? MT_MAX : ld_min_t;
            min_u_nx = (ld_min_u > 4'd9)   ? 4'd9   : ld_min_u;
            sec_t_nx = (ld_sec_t > 4'd5)   ? 4'd5   : ld_sec_t;
            sec_u_nx = (ld_sec_u > 4'd9)   ? 4'd9   : ld_sec_u;
        end else begin
            case (state)
                IDLE: if (start && !is_zero) state_nx = RUN;
                RUN: begin
                    if (pause) begin
                        state_nx = PAUSE;
                    end else if (ce) begin
                        if (is_one || is_zero) begin
                            // Final second: land on 00:00 and expire on the same edge.
                            sec_u_nx = 4'd0;
                            state_nx = EXPIRED;
                            done_nx  = is_one;
                        end else if (sec_u != 4'd0) begin
                            sec_u_nx = sec_u - 4'd1;
                        end else begin
                            sec_u_nx = 4'd9;
                            if (sec_t != 4'd0) begin
                                sec_t_nx = sec_t - 4'd1;
                            end else begin
                                sec_t_nx = 4'd5;
                                if (min_u != 4'd0) begin
                                    min_u_nx = min_u - 4'd1;
                                end else begin
                                    min_u_nx = 4'd9;
                                    min_t_nx = min_t - 4'd1;
                                end
                            end
                        end
                    end
                end
                PAUSE:   if (start) state_nx = RUN;
                EXPIRED: state_nx = EXPIRED;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            min_t <= 4'd0;
            min_u <= 4'd0;
            sec_t <= 4'd0;
            sec_u <= 4'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            min_t <= min_t_nx;
            min_u <= min_u_nx;
            sec_t <= sec_t_nx;
            sec_u <= sec_u_nx;
            done  <= done_nx;
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);
endmodule

// File: tb/tb_cnt_down_timer.sv
// Directed bench for cnt_down_timer: reset, countdown/expiry, borrows, pause, clamp, edge cases.
module tb_cnt_down_timer;
    logic       clk = 1'b0;
    logic       rst, ce, load, start, pause;
    logic [3:0] ld_min_t, ld_min_u, ld_sec_t, ld_sec_u;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, expired, done;
    logic [15:0] val;
    int errors = 0;
    int checks = 0;

    cnt_down_timer #(.MIN_T_MAX(5)) dut (
        .clk(clk), .rst(rst), .ce(ce), .load(load),
        .ld_min_t(ld_min_t), .ld_min_u(ld_min_u), .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
        .start(start), .pause(pause),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .expired(expired), .done(done)
    );

    always #5 clk = ~clk;
    assign val = {min_t, min_u, sec_t, sec_u};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; ce = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        idle_inputs();
        {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = v;
        load = 1; step(); load = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); rst = 1; ld_min_t = 0; ld_min_u = 0; ld_sec_t = 0; ld_sec_u = 0;
        step(); step(); rst = 0;
        checks++;
        if (val !== 16'h0000 || running !== 1'b0 || expired !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %h r=%b e=%b d=%b, want 0000 0 0 0", val, running, expired, done);
        end
    endtask

    task automatic test_countdown();
        do_load(16'h0003);
        start = 1; step(); start = 0;
        checks++;
        if (running !== 1'b1) begin errors++; $display("FAIL cd_run: got %b want 1", running); end
        ce = 1; step();
        checks++;
        if (val !== 16'h0002 || done !== 1'b0) begin errors++; $display("FAIL cd_2: got %h d=%b want 0002 d=0", val, done); end
        step();
        checks++;
        if (val !== 16'h0001 || done !== 1'b0) begin errors++; $display("FAIL cd_1: got %h d=%b want 0001 d=0", val, done); end
        step();
        checks++;
        if (val !== 16'h0000 || done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL cd_0: got %h d=%b e=%b r=%b want 0000 1 1 0", val, done, expired, running);
        end
        step(); ce = 0;
        checks++;
        if (val !== 16'h0000 || done !== 1'b0 || expired !== 1'b1) begin
            errors++; $display("FAIL cd_hold: got %h d=%b e=%b want 0000 0 1", val, done, expired);
        end
    endtask

    task automatic test_borrow();
        do_load(16'h1000);
        start = 1; step(); start = 0;
        ce = 1; step(); ce = 0;
        checks++;
        if (val !== 16'h0959) begin errors++; $display("FAIL borrow_10: got %h want 0959", val); end
        do_load(16'h0100);
        start = 1; step(); start = 0;
        ce = 1; step(); ce = 0;
        checks++;
        if (val !== 16'h0059) begin errors++; $display("FAIL borrow_01: got %h want 0059", val); end
    endtask

    task automatic test_pause();
        do_load(16'h0031);
        start = 1; step(); start = 0;
        ce = 1; step();
        checks++;
        if (val !== 16'h0030) begin errors++; $display("FAIL pause_pre: got %h want 0030", val); end
        pause = 1; step(); pause = 0;
        checks++;
        if (val !== 16'h0030 || running !== 1'b0) begin errors++; $display("FAIL pause_drop: got %h r=%b want 0030 0", val, running); end
        for (int i = 0; i < 5; i++) step();
        ce = 0;
        checks++;
        if (val !== 16'h0030) begin errors++; $display("FAIL pause_hold: got %h want 0030", val); end
        start = 1; step(); start = 0;
        checks++;
        if (val !== 16'h0030 || running !== 1'b1) begin errors++; $display("FAIL pause_resume: got %h r=%b want 0030 1", val, running); end
        ce = 1; step(); ce = 0;
        checks++;
        if (val !== 16'h0029) begin errors++; $display("FAIL pause_count: got %h want 0029", val); end
    endtask

    task automatic test_clamp_priority();
        do_load(16'h997C);
        checks++;
        if (val !== 16'h5959 || running !== 1'b0) begin errors++; $display("FAIL clamp: got %h r=%b want 5959 0", val, running); end
        {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = 16'h0005;
        load = 1; start = 1; step(); load = 0; start = 0;
        checks++;
        if (val !== 16'h0005 || running !== 1'b0) begin errors++; $display("FAIL load_start: got %h r=%b want 0005 0", val, running); end
    endtask

    task automatic test_edges();
        do_load(16'h0000);
        start = 1; step(); start = 0;
        checks++;
        if (running !== 1'b0 || expired !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL start_zero: r=%b e=%b d=%b want 0 0 0", running, expired, done);
        end
        do_load(16'h0001);
        start = 1; step(); start = 0;
        ce = 1; step(); ce = 0;
        start = 1; pause = 1; ce = 1; step(); start = 0; pause = 0; ce = 0;
        checks++;
        if (val !== 16'h0000 || expired !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL exp_hold: got %h e=%b r=%b d=%b want 0000 1 0 0", val, expired, running, done);
        end
        do_load(16'h0001);
        start = 1; step(); start = 0;
        rst = 1; ce = 1; step(); rst = 0; ce = 0;
        checks++;
        if (val !== 16'h0000 || done !== 1'b0 || running !== 1'b0 || expired !== 1'b0) begin
            errors++; $display("FAIL rst_run: got %h d=%b r=%b e=%b want 0000 0 0 0", val, done, running, expired);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_clamp_priority();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
